// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared width, state encoding and constants for the arithmetic
//               pipeline unwind divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  // Default pipeline word width
  localparam int PIPE_N = 10;

  // Divider control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Quotient reported for a divide by zero: all ones at the default width,
  // and the fill bit used to build it at any other width
  localparam logic              PIPE_DIVZ_FILL = 1'b1;
  localparam logic [PIPE_N-1:0] PIPE_DIVZ_Q    = {PIPE_N{PIPE_DIVZ_FILL}};

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/pipe_div_unwind_step.sv
// ============================================================================
// Module      : pipe_div_step
// Description : One combinational restoring-division iteration. Shifts the
//               next dividend bit into the partial remainder, trial-subtracts
//               the divisor and keeps the difference when it does not borrow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_div_step #(
  parameter int N = 10
) (
  input  logic [N-1:0] rem_i,      // current partial remainder (always < divisor)
  input  logic         dvd_msb_i,  // dividend bit being brought down
  input  logic [N-1:0] dsr_i,      // divisor
  output logic [N-1:0] rem_o,      // next partial remainder
  output logic         qbit_o      // quotient bit produced by this step
);

  logic [N:0] w_shift;
  logic [N:0] w_trial;
  logic       w_borrow;

  // Because rem_i < divisor, the shifted value is below 2*divisor, so the
  // trial magnitude is always under 2^N and bit N is exactly the borrow.
  always_comb begin
    w_shift  = {rem_i, dvd_msb_i};
    w_trial  = w_shift - {1'b0, dsr_i};
    w_borrow = w_trial[N];
    qbit_o   = ~w_borrow;
    rem_o    = w_borrow ? w_shift[N-1:0] : w_trial[N-1:0];
  end

endmodule : pipe_div_step

`default_nettype wire

// File: rtl/pipe_div_unwind.sv
// ============================================================================
// Module      : pipe_div_unwind
// Description : Iterative restoring divider (one quotient bit per clock) that
//               recovers q = f / d and r = f mod d from a pipeline product word
//               and its multiplier operand, with valid/ready on both sides.
//               Optional macro PIPE_DIV_FASTPATH_EN: resolve f < d in one clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_div_unwind
  import pipe_pkg::*;
#(
  parameter int N = PIPE_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] f,
  input  logic [N-1:0] d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         div_zero
);

  localparam int           CW       = $clog2(N + 1);
  localparam logic [N-1:0] C_DIVZ_Q = {N{PIPE_DIVZ_FILL}};

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  rem_q;      // partial remainder
  logic [N-1:0]  dvd_q;      // dividend bits still to consume, quotient shifts in
  logic [N-1:0]  dsr_q;      // latched divisor
  logic [N-1:0]  q_q;
  logic [N-1:0]  r_q;
  logic          divz_q;
  logic          short_q;    // op resolves without iterating (d == 0 or fast path)
  logic          short_dz_q; // the short op is a divide by zero

  logic          w_accept;
  logic          w_last;
  logic          w_fast;
  logic [N-1:0]  w_rem_next;
  logic          w_qbit;

  assign w_accept = (state_q == IDLE) && in_valid;
  assign w_last   = (state_q == BUSY) && (cnt_q == CW'(1));

`ifdef PIPE_DIV_FASTPATH_EN
  assign w_fast = (f < d);
`else
  assign w_fast = 1'b0;
`endif

  pipe_div_step #(.N(N)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[N-1]),
    .dsr_i     (dsr_q),
    .rem_o     (w_rem_next),
    .qbit_o    (w_qbit)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = BUSY;
      end
      BUSY: begin
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iteration and result load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dsr_q      <= '0;
      q_q        <= '0;
      r_q        <= '0;
      divz_q     <= 1'b0;
      short_q    <= 1'b0;
      short_dz_q <= 1'b0;
    end else if (w_accept) begin
      dvd_q  <= f;
      dsr_q  <= d;
      rem_q  <= '0;
      divz_q <= 1'b0;
      if (d == '0) begin
        // Divide by zero: one clock, no iterations
        cnt_q      <= CW'(1);
        short_q    <= 1'b1;
        short_dz_q <= 1'b1;
      end else if (w_fast) begin
        cnt_q      <= CW'(1);
        short_q    <= 1'b1;
        short_dz_q <= 1'b0;
      end else begin
        cnt_q      <= CW'(N);
        short_q    <= 1'b0;
        short_dz_q <= 1'b0;
      end
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q - CW'(1);
      if (!short_q) begin
        rem_q <= w_rem_next;
        dvd_q <= {dvd_q[N-2:0], w_qbit};
      end
      if (w_last) begin
        if (short_q) begin
          // dvd_q still holds f untouched on the short path
          q_q    <= short_dz_q ? C_DIVZ_Q : '0;
          r_q    <= dvd_q;
          divz_q <= short_dz_q;
        end else begin
          q_q    <= {dvd_q[N-2:0], w_qbit};
          r_q    <= w_rem_next;
          divz_q <= 1'b0;
        end
      end
    end
  end

  assign q        = q_q;
  assign r        = r_q;
  assign div_zero = divz_q;

endmodule : pipe_div_unwind

`default_nettype wire

// File: tb/tb_pipe_div_unwind.sv
// ============================================================================
// Module      : tb_pipe_div_unwind
// Description : Self-checking bench for pipe_div_unwind: vector table driven
//               through a result scoreboard, plus backpressure and mid-op
//               reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_div_unwind;
  import pipe_pkg::*;

  localparam int N = PIPE_N;
`ifdef PIPE_DIV_FASTPATH_EN
  localparam int FASTLAT = 1;
`else
  localparam int FASTLAT = N;
`endif

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b1;
  logic [N-1:0] f         = '0;
  logic [N-1:0] d         = '0;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         div_zero;

  always #5 clk = ~clk;

  pipe_div_unwind #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .f         (f),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .div_zero  (div_zero)
  );

  typedef struct {
    logic [N-1:0] f;
    logic [N-1:0] d;
    logic [N-1:0] eq;
    logic [N-1:0] er;
    logic         edz;
  } vec_t;

  typedef struct {
    logic [N-1:0] eq;
    logic [N-1:0] er;
    logic         edz;
    int           elat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_lat(input logic [N-1:0] fv, input logic [N-1:0] dv);
    if (dv == '0)   return 1;
    else if (fv < dv) return FASTLAT;
    else            return N;
  endfunction

  // Present one op, wait for the accepting edge, record its expected result
  task automatic drive(input logic [N-1:0] fv, input logic [N-1:0] dv,
                       input logic [N-1:0] eq, input logic [N-1:0] er, input logic edz);
    exp_t e;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    f        = fv;
    d        = dv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e.eq   = eq;
    e.er   = er;
    e.edz  = edz;
    e.elat = exp_lat(fv, dv);
    sb.push_back(e);
  endtask

  // Wait (bounded) for out_valid, then compare against the oldest expectation
  task automatic collect();
    int   lat;
    exp_t e;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      chk("out_valid_timeout", 32'(out_valid), 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("latency", 32'(lat), 32'(e.elat));
    chk("q", 32'(q), 32'(e.eq));
    chk("r", 32'(r), 32'(e.er));
    chk("div_zero", 32'(div_zero), 32'(e.edz));
    chk("in_ready_done", 32'(in_ready), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    drive(v.f, v.d, v.eq, v.er, v.edz);
    collect();
    @(posedge clk);
    #1;
    chk("back_to_idle_valid", 32'(out_valid), 32'd0);
    chk("back_to_idle_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{f: 10'd75,   d: 10'd3,    eq: 10'd25,   er: 10'd0,   edz: 1'b0};
    vecs[1] = '{f: 10'd100,  d: 10'd7,    eq: 10'd14,   er: 10'd2,   edz: 1'b0};
    vecs[2] = '{f: 10'd1023, d: 10'd1,    eq: 10'd1023, er: 10'd0,   edz: 1'b0};
    vecs[3] = '{f: 10'd1023, d: 10'd1023, eq: 10'd1,    er: 10'd0,   edz: 1'b0};
    vecs[4] = '{f: 10'd37,   d: 10'd0,    eq: 10'd1023, er: 10'd37,  edz: 1'b1};
    vecs[5] = '{f: 10'd8,    d: 10'd2,    eq: 10'd4,    er: 10'd0,   edz: 1'b0};
    vecs[6] = '{f: 10'd5,    d: 10'd9,    eq: 10'd0,    er: 10'd5,   edz: 1'b0};
    vecs[7] = '{f: 10'd1000, d: 10'd33,   eq: 10'd30,   er: 10'd10,  edz: 1'b0};
    vecs[8] = '{f: 10'd512,  d: 10'd1000, eq: 10'd0,    er: 10'd512, edz: 1'b0};
    vecs[9] = '{f: 10'd0,    d: 10'd5,    eq: 10'd0,    er: 10'd0,   edz: 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_div_zero", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
    end

    // Backpressure: result held for 20 clocks while inputs wiggle
    out_ready = 1'b0;
    drive(10'd300, 10'd7, 10'd42, 10'd6, 1'b0);
    collect();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      f        = N'($urandom);
      d        = N'($urandom);
      in_valid = 1'($urandom);
      @(posedge clk);
      #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_q", 32'(q), 32'd42);
      chk("bp_r", 32'(r), 32'd6);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);

    // Reset four clocks into an operation
    drive(10'd200, 10'd6, 10'd33, 10'd2, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_q", 32'(q), 32'd0);
    chk("midrst_r", 32'(r), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_vec('{f: 10'd200, d: 10'd6, eq: 10'd33, er: 10'd2, edz: 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pipe_div_unwind

`default_nettype wire
